counter_timer_high: RTL and testbench
=====================================

// Module: counter_timer_high
// PURPOSE
//  Upper word of the chained 64-bit Caravel counter/timer, or a standalone 32-bit counter/timer.
//  Sits beside counter_timer_low and consumes its strobe, is_offset, enable_out and stop_out.
//  Returns enable_out and stop_out to the low word.
//  Counts once per low-word strobe when chained, and once per clock otherwise.
// PARAMETERS
//  WIDTH  32  counter/reload register width; byte write enables cover WIDTH/8 bytes
// PORTS
//  clkin       in   1      clock; sole clock domain
//  resetn      in   1      asynchronous, active-low reset
//  reg_cfg_we  in   1      write config from reg_cfg_di[4:0]
//  reg_cfg_di  in   32     config write data
//  reg_cfg_do  out  32     {27'd0, irq_ena, chain, updown, oneshot, enable}
//  reg_val_we  in   4      per-byte write enable, reload/terminal value
//  reg_val_di  in   WIDTH  reload value write data
//  reg_val_do  out  WIDTH  value_reset
//  reg_dat_we  in   4      per-byte write enable, current count
//  reg_dat_di  in   WIDTH  current count write data
//  reg_dat_do  out  WIDTH  value_cur
//  enable_in   in   1      low word enable_out
//  strobe_in   in   1      low word rollover strobe; count step when chained
//  is_offset   in   1      low word is up-counting with reload 0; high target is reduced by 1
//  stop_in     in   1      low word stop_out
//  enable_out  out  1      cfg enable, combinational; drives low enable_in
//  stop_out    out  1      registered high-word terminal flag; drives low stop_in
//  irq_out     out  1      one-cycle timeout interrupt
// BEHAVIOUR
//  Reset values: all registers and outputs are 0 (cfg, value_reset, value_cur, lastenable, stop_out, irq_out, term_d).
//  Enable logic:
//   - loc_enable = chain ? (enable & enable_in) : enable.
//   - lastenable <= loc_enable every cycle.
//  Count step: step = chain ? strobe_in : 1.
//  Terminal value (tgt):
//   - up mode: value_reset - (chain & is_offset), taken modulo 2^WIDTH (0 - 1 wraps to all ones).
//   - down mode: 0.
//  Priority per clock, highest first:
//   1. reg_dat_we != 0: byte-write value_cur; no count this cycle; stop_out recomputed against the new value.
//   2. !loc_enable: value_cur and stop_out hold; strobe_in is ignored.
//   3. loc_enable & !lastenable (start): value_cur <= up ? 0 : value_reset.
//   4. Terminal reached:
//      - standalone: value_cur == tgt and step; chained: stop_out & stop_in.
//      - oneshot=1: value_cur holds, stop_out stays 1.
//      - oneshot=0: reload start value (up 0, down value_reset).
//   5. step: value_cur <= up ? value_cur + 1 : value_cur - 1, modulo 2^WIDTH.
//  stop_out <= (next value_cur == tgt); it stays high for as long as the count sits at tgt.
//  Config writes:
//   - A cfg write takes effect the next cycle.
//   - Clearing enable freezes the count.
//   - Re-enabling restarts from the start value.
//  value_reset writes are byte-wise. A write while running retargets immediately; no reload.
//  Wrap-around: an up count past all ones (up-count to all ones with value_reset = 0 and is_offset = 1) gives tgt = all ones and is legal.
// CONFIGURATION
//  COUNTER_TIMER_HIGH_IRQ_EN defined:
//   - term = chain ? (stop_out & stop_in) : stop_out.
//   - term_d <= term.
//   - irq_out <= irq_ena & term & ~term_d: exactly one cycle per timeout.
//  COUNTER_TIMER_HIGH_IRQ_EN undefined:
//   - irq_out tied 0.
//   - irq_ena is not stored and reg_cfg_do[4] reads 0.
// STRUCTURE
//  Package counter_timer_pkg: cfg bit indices (CFG_ENABLE=0, CFG_ONESHOT=1, CFG_UPDOWN=2, CFG_CHAIN=3, CFG_IRQENA=4).
//  The low word shares the same package.
//  One sub-module, counter_timer_bytereg:
//   - WIDTH-bit register with per-byte write enable and asynchronous active-low clear.
//   - Instantiated for value_reset.
//   - value_cur stays inline because it also counts.
// TESTING
//  1. Standalone down: value_reset=5, cfg=0x01, oneshot=0.
//     -> value_cur 5,4,3,2,1,0,5...; stop_out high in the cycle value_cur reads 0.
//  2. Standalone up oneshot irq: value_reset=3, cfg=0x17.
//     -> counts 0..3 then holds at 3; stop_out=1; one irq_out pulse, none after.
//  3. Chained up: value_reset=2, chain=1, enable_in=1, three strobe_in pulses 10 cycles apart.
//     -> value_cur 1,2 after 2 strobes and stop_out=1; stop_in=1 with oneshot=0 reloads 0.
//  4. is_offset=1, value_reset=0, chain up -> tgt=0xFFFFFFFF; stop_out=1 only after value_cur wraps to all ones.
//  5. Dat write racing a strobe: reg_dat_we=4'hF, di=0x10 on a strobe_in cycle.
//     -> value_cur=0x10, no increment that cycle.
//  6. resetn low mid-count (value_cur=7, stop_out=1) -> all outputs 0 asynchronously.
//     -> after release, idle until cfg is written.

Source files
------------

// File: rtl/counter_timer_pkg.sv
// counter_timer_pkg: config register bit positions shared by the low and high counter/timer words.
package counter_timer_pkg;
    localparam int CFG_ENABLE  = 0;
    localparam int CFG_ONESHOT = 1;
    localparam int CFG_UPDOWN  = 2;
    localparam int CFG_CHAIN   = 3;
    localparam int CFG_IRQENA  = 4;
    localparam int CFG_BITS    = 5;
endpackage

// File: rtl/counter_timer_high_if.sv
// counter_timer_high_if: register bus plus low-word chaining signals of the high counter/timer word.
//   master: drives register writes and the low-word inputs (enable_in, strobe_in, is_offset, stop_in)
//   slave : the counter; returns readback data, enable_out, stop_out and irq_out
interface counter_timer_high_if #(parameter int WIDTH = 32);
    logic                 reg_cfg_we;
    logic [31:0]          reg_cfg_di;
    logic [31:0]          reg_cfg_do;
    logic [WIDTH/8-1:0]   reg_val_we;
    logic [WIDTH-1:0]     reg_val_di;
    logic [WIDTH-1:0]     reg_val_do;
    logic [WIDTH/8-1:0]   reg_dat_we;
    logic [WIDTH-1:0]     reg_dat_di;
    logic [WIDTH-1:0]     reg_dat_do;
    logic                 enable_in;
    logic                 strobe_in;
    logic                 is_offset;
    logic                 stop_in;
    logic                 enable_out;
    logic                 stop_out;
    logic                 irq_out;
    modport master (
        output reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
               enable_in, strobe_in, is_offset, stop_in,
        input  reg_cfg_do, reg_val_do, reg_dat_do, enable_out, stop_out, irq_out
    );
    modport slave (
        input  reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
               enable_in, strobe_in, is_offset, stop_in,
        output reg_cfg_do, reg_val_do, reg_dat_do, enable_out, stop_out, irq_out
    );
endinterface

// File: rtl/counter_timer_bytereg.sv
// counter_timer_bytereg: WIDTH-bit register with per-byte write enables and async active-low clear.
//   i_clk, i_rst_n : clock, asynchronous active-low clear
//   i_we           : one write enable per byte
//   i_d / o_q      : write data / register contents
module counter_timer_bytereg #(parameter int WIDTH = 32) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH/8-1:0]   i_we,
    input  logic [WIDTH-1:0]     i_d,
    output logic [WIDTH-1:0]     o_q
);
    for (genvar b = 0; b < WIDTH/8; b++) begin : g_byte
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) o_q[8*b +: 8] <= '0;
            else if (i_we[b]) o_q[8*b +: 8] <= i_d[8*b +: 8];
        end
    end
endmodule

// File: rtl/counter_timer_high.sv
// counter_timer_high: upper word of the chained 64-bit counter/timer, or a standalone WIDTH-bit counter/timer.
//   clkin, resetn : clock, asynchronous active-low reset
//   bus (slave)   : cfg/value/data registers, low-word chaining inputs, enable_out/stop_out/irq_out
//   Build option COUNTER_TIMER_HIGH_IRQ_EN: stores irq_ena and generates a one-cycle timeout irq_out;
//   without it irq_out is 0 and cfg bit 4 reads 0.
module counter_timer_high
    import counter_timer_pkg::*;
#(parameter int WIDTH = 32) (
    input  logic                  clkin,
    input  logic                  resetn,
    counter_timer_high_if.slave   bus
);
`ifdef COUNTER_TIMER_HIGH_IRQ_EN
    localparam logic [CFG_BITS-1:0] CFG_MASK = 5'h1f;
`else
    localparam logic [CFG_BITS-1:0] CFG_MASK = 5'h0f;
`endif
    logic [CFG_BITS-1:0] r_cfg;
    logic [WIDTH-1:0]    r_cur;
    logic                r_last;
    logic                r_stop;
    logic [WIDTH-1:0]    w_val;
    logic [WIDTH-1:0]    w_dat_wr;
    logic [WIDTH-1:0]    w_tgt;
    logic [WIDTH-1:0]    w_start;
    logic [WIDTH-1:0]    w_cur_nxt;
    logic                w_en, w_oneshot, w_up, w_chain, w_loc_en, w_step, w_term, w_dat_we;
    logic                w_unused_cfg;
    assign w_en         = r_cfg[CFG_ENABLE];
    assign w_oneshot    = r_cfg[CFG_ONESHOT];
    assign w_up         = r_cfg[CFG_UPDOWN];
    assign w_chain      = r_cfg[CFG_CHAIN];
    assign w_loc_en     = w_chain ? (w_en & bus.enable_in) : w_en;
    assign w_step       = w_chain ? bus.strobe_in : 1'b1;
    assign w_dat_we     = |bus.reg_dat_we;
    assign w_unused_cfg = ^bus.reg_cfg_di[31:CFG_BITS];
    counter_timer_bytereg #(.WIDTH(WIDTH)) u_val (
        .i_clk   (clkin),
        .i_rst_n (resetn),
        .i_we    (bus.reg_val_we),
        .i_d     (bus.reg_val_di),
        .o_q     (w_val)
    );
    always_comb begin
        w_dat_wr = r_cur;
        for (int i = 0; i < WIDTH/8; i++)
            if (bus.reg_dat_we[i]) w_dat_wr[8*i +: 8] = bus.reg_dat_di[8*i +: 8];
        // In chained up mode with an offset low word the high word must stop one step early.
        w_tgt     = w_up ? w_val - WIDTH'(w_chain & bus.is_offset) : '0;
        w_start   = w_up ? '0 : w_val;
        w_term    = w_chain ? (r_stop & bus.stop_in) : (r_cur == w_tgt) && w_step;
        w_cur_nxt = w_dat_we  ? w_dat_wr :
                    !w_loc_en ? r_cur :
                    !r_last   ? w_start :
                    w_term    ? (w_oneshot ? r_cur : w_start) :
                    w_step    ? (w_up ? r_cur + WIDTH'(1) : r_cur - WIDTH'(1)) :
                                r_cur;
    end
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_cfg  <= '0;
            r_cur  <= '0;
            r_last <= 1'b0;
            r_stop <= 1'b0;
        end else begin
            if (bus.reg_cfg_we) r_cfg <= bus.reg_cfg_di[CFG_BITS-1:0] & CFG_MASK;
            r_cur  <= w_cur_nxt;
            r_last <= w_loc_en;
            if (w_dat_we || w_loc_en) r_stop <= (w_cur_nxt == w_tgt);
        end
    end
`ifdef COUNTER_TIMER_HIGH_IRQ_EN
    logic r_term_d, r_irq, w_irq_term;
    assign w_irq_term = w_chain ? (r_stop & bus.stop_in) : r_stop;
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_term_d <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_term_d <= w_irq_term;
            r_irq    <= r_cfg[CFG_IRQENA] & w_irq_term & ~r_term_d;
        end
    end
    assign bus.irq_out = r_irq;
`else
    assign bus.irq_out = 1'b0;
`endif
    assign bus.reg_cfg_do = {{(32-CFG_BITS){1'b0}}, r_cfg};
    assign bus.reg_val_do = w_val;
    assign bus.reg_dat_do = r_cur;
    assign bus.enable_out = w_en;
    assign bus.stop_out   = r_stop;
endmodule

// File: tb/tb_counter_timer_high.sv
// tb_counter_timer_high: scoreboard bench for counter_timer_high (standalone, chained, offset, races, reset).
module tb_counter_timer_high;
    typedef struct packed {
        logic [31:0] cur;
        logic        stop;
    } exp_t;
`ifdef COUNTER_TIMER_HIGH_IRQ_EN
    localparam int          IRQ_EXP = 1;
    localparam logic [31:0] CFG_RB  = 32'h17;
`else
    localparam int          IRQ_EXP = 0;
    localparam logic [31:0] CFG_RB  = 32'h07;
`endif
    logic clkin = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];
    counter_timer_high_if #(.WIDTH(32)) bus ();
    counter_timer_high #(.WIDTH(32)) dut (.clkin(clkin), .resetn(resetn), .bus(bus));
    always #5 clkin = ~clkin;
    task automatic tick();
        @(posedge clkin);
        #1;
    endtask
    task automatic wr_cfg(input logic [31:0] v);
        bus.reg_cfg_we = 1'b1; bus.reg_cfg_di = v;
        tick();
        bus.reg_cfg_we = 1'b0;
    endtask
    task automatic wr_val(input logic [31:0] v);
        bus.reg_val_we = 4'hf; bus.reg_val_di = v;
        tick();
        bus.reg_val_we = 4'h0;
    endtask
    task automatic test_reset();
        repeat (2) tick();
        n_chk++;
        if ({bus.reg_cfg_do, bus.reg_val_do, bus.reg_dat_do, bus.stop_out, bus.irq_out, bus.enable_out} !== '0)
            $display("FAIL reset: cfg=%h val=%h dat=%h stop=%b irq=%b en=%b, want all 0",
                     bus.reg_cfg_do, bus.reg_val_do, bus.reg_dat_do, bus.stop_out, bus.irq_out, bus.enable_out);
        else n_pass++;
        resetn = 1'b1;
        tick();
    endtask
    task automatic test_down();
        exp_t e;
        logic [31:0] v = 32'd5;
        wr_val(32'd5);
        n_chk++;
        if (bus.reg_val_do !== 32'd5) $display("FAIL down_val_rb: got %h want 5", bus.reg_val_do);
        else n_pass++;
        wr_cfg(32'h1);
        for (int i = 0; i < 8; i++) begin
            q.push_back('{cur: v, stop: (v == 32'd0)});
            v = (v == 32'd0) ? 32'd5 : v - 32'd1;
            tick();
            e = q.pop_front();
            n_chk++;
            if (bus.reg_dat_do !== e.cur || bus.stop_out !== e.stop)
                $display("FAIL down_step%0d: cur=%h stop=%b want cur=%h stop=%b", i, bus.reg_dat_do, bus.stop_out, e.cur, e.stop);
            else n_pass++;
        end
        wr_cfg(32'h0);
        repeat (3) tick();
        n_chk++;
        if (bus.reg_dat_do !== v || bus.enable_out !== 1'b0)
            $display("FAIL down_freeze: cur=%h en=%b want cur=%h en=0", bus.reg_dat_do, bus.enable_out, v);
        else n_pass++;
    endtask
    task automatic test_up_oneshot();
        exp_t e;
        logic [31:0] v = 32'd0;
        int n_irq = 0;
        wr_val(32'd3);
        wr_cfg(32'h17);
        n_chk++;
        if (bus.reg_cfg_do !== CFG_RB) $display("FAIL cfg_rb: got %h want %h", bus.reg_cfg_do, CFG_RB);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            q.push_back('{cur: v, stop: (v == 32'd3)});
            v = (v == 32'd3) ? 32'd3 : v + 32'd1;
            tick();
            n_irq += int'(bus.irq_out);
            e = q.pop_front();
            n_chk++;
            if (bus.reg_dat_do !== e.cur || bus.stop_out !== e.stop)
                $display("FAIL up_step%0d: cur=%h stop=%b want cur=%h stop=%b", i, bus.reg_dat_do, bus.stop_out, e.cur, e.stop);
            else n_pass++;
        end
        repeat (5) begin
            tick();
            n_irq += int'(bus.irq_out);
        end
        n_chk++;
        if (n_irq != IRQ_EXP) $display("FAIL irq_count: got %0d want %0d", n_irq, IRQ_EXP);
        else n_pass++;
        wr_cfg(32'h0);
    endtask
    task automatic test_chained();
        exp_t e;
        logic [31:0] m = 32'd0;
        logic        ms = 1'b0;
        wr_val(32'd2);
        bus.enable_in = 1'b1;
        wr_cfg(32'h0d);
        tick();
        n_chk++;
        if (bus.reg_dat_do !== 32'd0 || bus.stop_out !== 1'b0 || bus.enable_out !== 1'b1)
            $display("FAIL chain_start: cur=%h stop=%b en=%b want 0 0 1", bus.reg_dat_do, bus.stop_out, bus.enable_out);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            bus.strobe_in = 1'b1;
            bus.stop_in   = (k == 2);
            m  = (k == 2 && ms) ? 32'd0 : m + 32'd1;
            ms = (m == 32'd2);
            q.push_back('{cur: m, stop: ms});
            tick();
            bus.strobe_in = 1'b0;
            bus.stop_in   = 1'b0;
            e = q.pop_front();
            n_chk++;
            if (bus.reg_dat_do !== e.cur || bus.stop_out !== e.stop)
                $display("FAIL chain_strobe%0d: cur=%h stop=%b want cur=%h stop=%b", k, bus.reg_dat_do, bus.stop_out, e.cur, e.stop);
            else n_pass++;
            repeat (9) tick();
            n_chk++;
            if (bus.reg_dat_do !== e.cur) $display("FAIL chain_hold%0d: cur=%h want %h", k, bus.reg_dat_do, e.cur);
            else n_pass++;
        end
        bus.enable_in = 1'b0;
        bus.strobe_in = 1'b1;
        tick();
        bus.strobe_in = 1'b0;
        n_chk++;
        if (bus.reg_dat_do !== m) $display("FAIL chain_gated: cur=%h want %h", bus.reg_dat_do, m);
        else n_pass++;
        wr_cfg(32'h0);
    endtask
    task automatic test_offset();
        exp_t e;
        logic [31:0] m = 32'hffff_fffd;
        wr_val(32'd0);
        bus.is_offset = 1'b1;
        bus.enable_in = 1'b1;
        wr_cfg(32'h0d);
        tick();
        bus.reg_dat_we = 4'hf; bus.reg_dat_di = m;
        tick();
        bus.reg_dat_we = 4'h0;
        n_chk++;
        if (bus.reg_dat_do !== m || bus.stop_out !== 1'b0)
            $display("FAIL offset_load: cur=%h stop=%b want %h 0", bus.reg_dat_do, bus.stop_out, m);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            bus.strobe_in = 1'b1;
            m = m + 32'd1;
            q.push_back('{cur: m, stop: (m == 32'hffff_ffff)});
            tick();
            bus.strobe_in = 1'b0;
            e = q.pop_front();
            n_chk++;
            if (bus.reg_dat_do !== e.cur || bus.stop_out !== e.stop)
                $display("FAIL offset_step%0d: cur=%h stop=%b want cur=%h stop=%b", k, bus.reg_dat_do, bus.stop_out, e.cur, e.stop);
            else n_pass++;
        end
    endtask
    task automatic test_dat_race();
        exp_t e;
        logic [3:0]  we[3] = '{4'hf, 4'h2, 4'h0};
        logic [31:0] di[3] = '{32'h10, 32'h0000_ab00, 32'h0};
        logic [31:0] ex[3] = '{32'h10, 32'h0000_ab10, 32'h0000_ab11};
        for (int k = 0; k < 3; k++) begin
            bus.reg_dat_we = we[k]; bus.reg_dat_di = di[k]; bus.strobe_in = 1'b1;
            q.push_back('{cur: ex[k], stop: 1'b0});
            tick();
            bus.reg_dat_we = 4'h0; bus.strobe_in = 1'b0;
            e = q.pop_front();
            n_chk++;
            if (bus.reg_dat_do !== e.cur || bus.stop_out !== e.stop)
                $display("FAIL dat_race%0d: cur=%h stop=%b want cur=%h stop=%b", k, bus.reg_dat_do, bus.stop_out, e.cur, e.stop);
            else n_pass++;
        end
        bus.is_offset = 1'b0;
        wr_cfg(32'h0);
    endtask
    task automatic test_reset_mid();
        wr_val(32'd7);
        wr_cfg(32'h05);
        repeat (8) tick();
        n_chk++;
        if (bus.reg_dat_do !== 32'd7 || bus.stop_out !== 1'b1)
            $display("FAIL mid_pre: cur=%h stop=%b want 7 1", bus.reg_dat_do, bus.stop_out);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_chk++;
        if ({bus.reg_cfg_do, bus.reg_val_do, bus.reg_dat_do, bus.stop_out, bus.irq_out, bus.enable_out} !== '0)
            $display("FAIL mid_async: cfg=%h val=%h dat=%h stop=%b irq=%b en=%b, want all 0",
                     bus.reg_cfg_do, bus.reg_val_do, bus.reg_dat_do, bus.stop_out, bus.irq_out, bus.enable_out);
        else n_pass++;
        @(negedge clkin) resetn = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (bus.reg_dat_do !== 32'd0 || bus.stop_out !== 1'b0 || bus.reg_cfg_do !== 32'd0)
            $display("FAIL mid_idle: cur=%h stop=%b cfg=%h want 0 0 0", bus.reg_dat_do, bus.stop_out, bus.reg_cfg_do);
        else n_pass++;
    endtask
    initial begin
        bus.reg_cfg_we = 1'b0; bus.reg_cfg_di = '0;
        bus.reg_val_we = '0;   bus.reg_val_di = '0;
        bus.reg_dat_we = '0;   bus.reg_dat_di = '0;
        bus.enable_in  = 1'b0; bus.strobe_in  = 1'b0;
        bus.is_offset  = 1'b0; bus.stop_in    = 1'b0;
        test_reset();
        test_down();
        test_up_oneshot();
        test_chained();
        test_offset();
        test_dat_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
